serial_alu: RTL and testbench
=============================

# serial_alu

Bit-serial WIDTH-bit ALU engine that sits directly upstream of the 1-bit ALU slice. It captures two operands and an operation, feeds one bit pair per cycle (LSB first) through a single 1-bit slice with a registered carry, and assembles the result into a WIDTH-bit output register. It uses the same 3-bit control encoding as the slice, and reports completion and status flags with a start/busy/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits; WIDTH ≥ 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A; captured on accepted start.
- B  input  WIDTH  operand B; captured on accepted start.
- control  input  3  operation; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; `out` and flags are valid.
- out  output  WIDTH  result register; holds until next completion.
- zero  output  1  out == 0.
- negative  output  1  out[WIDTH-1].
- overflow  output  1  signed overflow of add/sub.

## Operation
- control encoding: 010 add, 011 sub (A + ~B + 1), 100 and, 101 or, 110 nor, 111 xor. 000/001 are reserved; each bit result is 0 and carry is held at 0.
- States:
  - IDLE: start=1 → RUN.
  - RUN: runs for WIDTH cycles; after the last bit → DONE.
  - DONE: lasts one cycle; start=1 → RUN; otherwise → IDLE.
- Accepted start loads:
  - opA ← A, opB ← B, op ← control, bit counter ← 0.
  - carry ← 1 if control == 011, else 0.
- Each RUN cycle:
  - sum = opA[0] ^ b' ^ carry, with b' = opB[0] ^ op[0] for add/sub.
  - carry ← majority(opA[0], b', carry).
  - Logical ops use opA[0]/opB[0] directly and leave carry unchanged.
  - opA and opB shift right by 1; the result shift register shifts right with the new bit entering at MSB.
  - The counter increments.
- Last RUN cycle (counter == WIDTH-1):
  - The carry into the MSB is saved as cin_msb.
  - out ← the completed shift register.
  - overflow ← cin_msb ^ carry_out for add/sub; 0 otherwise.
- start is ignored while in RUN. Changes on A/B/control after capture have no effect.
- Reset (asserted at any time, including mid-RUN):
  - state → IDLE.
  - out, zero, negative, overflow, busy, done, carry and counter → 0.
  - Operation resumes on the first clk edge after deassertion.
- The serial carry chain wraps silently: the final carry-out is not exported and only feeds the overflow computation.

## Timing
- Start sampled high at edge 0 (IDLE). busy=1 from edge 0 through edge WIDTH.
- Bits 0..WIDTH-1 are processed at edges 1..WIDTH.
- out and flags update at edge WIDTH. done=1 for exactly one cycle after edge WIDTH.
- Latency from the start edge to the done cycle is WIDTH cycles (32 by default).
- Back-to-back: start high during the DONE cycle is accepted at edge WIDTH+1. busy rises again with no idle bubble.
- zero and negative are registered alongside out; they are not derived combinationally from the shift register.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- SERIAL_ALU_FLAGS_EN:
  - Defined: zero, negative and overflow behave as specified, and the cin_msb register exists.
  - Undefined: the three flag outputs are tied to 0, the flag logic and cin_msb are removed, and out/done timing is unchanged.

## Test plan
- Add with overflow: reset low 2 cycles, release; start with A=0x7FFFFFFF, B=0x00000001, control=010 → done exactly 32 cycles after the start edge; out=0x80000000, negative=1, overflow=1, zero=0.
- Subtract to zero: A=0x00000005, B=0x00000005, control=011 → out=0x00000000, zero=1, overflow=0. Then A=0x80000000, B=0x00000001, sub → out=0x7FFFFFFF, overflow=1.
- Logical ops on A=0xF0F0AAAA, B=0x0FF05555:
  - and → 0x00F00000.
  - or → 0xFFF0FFFF.
  - nor → 0x000F0000.
  - xor → 0xFF00FFFF.
  - overflow=0 for all four.
- Handshake robustness:
  - Pulse start again at RUN cycle 10 with different operands → ignored; the original result is returned at cycle 32.
  - Start held high in the DONE cycle → new operation begins with no IDLE cycle, and done recurs 32 cycles later.
- Reset mid-operation: assert reset at RUN cycle 15 → busy, done, out and flags are 0 immediately (asynchronously). After release with no start, done stays 0 for 40 cycles.
- Macro off: rebuild without SERIAL_ALU_FLAGS_EN and repeat the first scenario → out=0x80000000, done timing identical, zero/negative/overflow are 0.

Source files
------------

// File: rtl/serial_alu.sv
// serial_alu -- bit-serial WIDTH-bit ALU built around a single 1-bit slice.
//
// Captures A, B and control on an accepted start. It then processes one bit
// pair per cycle, LSB first, through a 1-bit slice with a registered carry.
// The completed word is loaded into `out` after WIDTH cycles.
//
// Control encoding: 010 add, 011 sub, 100 and, 101 or, 110 nor, 111 xor.
// 000/001 are reserved: each result bit is 0 and the carry stays 0.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     request; sampled only in IDLE or DONE
//   A, B      WIDTH-bit operands, captured on an accepted start
//   control   3-bit operation, captured on an accepted start
//   busy      high while the engine is in RUN
//   done      one-cycle pulse; out and flags are valid
//   out       result register; holds until the next completion
//   zero      out == 0
//   negative  out[WIDTH-1]
//   overflow  signed overflow of add/sub
//
// Optional feature macro: SERIAL_ALU_FLAGS_EN.
//   Defined:   zero/negative/overflow are generated.
//   Undefined: all three flags are tied to 0. out/done timing is unchanged.

module serial_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b, res, res_nx;
    logic [2:0]       op;
    logic [CW-1:0]    cnt;
    logic             carry, carry_nx, bit_r, b_eff;
    logic             accept, last, is_arith;

    assign accept   = start && (state == IDLE || state == DONE);
    assign last     = (state == RUN) && (cnt == CW'(WIDTH - 1));
    assign is_arith = (op[2:1] == 2'b01);

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The 1-bit slice. Subtract inverts B here; the +1 comes from the preset carry.
    always_comb begin
        b_eff    = op_b[0] ^ op[0];
        bit_r    = 1'b0;
        carry_nx = carry;
        case (op)
            3'b010, 3'b011: begin
                bit_r    = op_a[0] ^ b_eff ^ carry;
                carry_nx = (op_a[0] & b_eff) | (op_a[0] & carry) | (b_eff & carry);
            end
            3'b100:  bit_r = op_a[0] & op_b[0];
            3'b101:  bit_r = op_a[0] | op_b[0];
            3'b110:  bit_r = ~(op_a[0] | op_b[0]);
            3'b111:  bit_r = op_a[0] ^ op_b[0];
            default: carry_nx = 1'b0;
        endcase
        res_nx = {bit_r, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            op    <= '0;
            res   <= '0;
            out   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == RUN);
            done  <= last;
            if (accept) begin
                op_a  <= A;
                op_b  <= B;
                op    <= control;
                cnt   <= '0;
                carry <= (control == 3'b011);
            end else if (state == RUN) begin
                op_a  <= op_a >> 1;
                op_b  <= op_b >> 1;
                res   <= res_nx;
                cnt   <= cnt + CW'(1);
                carry <= carry_nx;
                if (last) out <= res_nx;
            end
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    // During the final RUN cycle the carry register holds the carry into the MSB.
    // This value is kept as cin_msb for the overflow computation.
    logic cin_msb;
    assign cin_msb = carry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else if (last) begin
            zero     <= (res_nx == '0);
            negative <= res_nx[WIDTH-1];
            overflow <= is_arith & (cin_msb ^ carry_nx);
        end
    end
`else
    logic unused_flags;
    assign unused_flags = is_arith;
    assign zero         = 1'b0;
    assign negative     = 1'b0;
    assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=32).
// It uses directed vectors with hand-computed results. Flag expectations
// collapse to 0 when SERIAL_ALU_FLAGS_EN is not defined.

module tb_serial_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic [2:0]   control = '0;
    logic         busy, done, zero, negative, overflow;
    logic [W-1:0] out;

    int checks = 0;
    int errors = 0;

    serial_alu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .control(control),
        .busy(busy), .done(done), .out(out), .zero(zero), .negative(negative),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic fx(input logic v);
`ifdef SERIAL_ALU_FLAGS_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // Present a start at the next falling edge. Return after the accepting edge (edge 0).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
        @(negedge clk);
        A = a; B = b; control = c; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after edge 0. Returns the edge count until done is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] c, input logic [W-1:0] exp,
                          input logic z, input logic n, input logic v);
        int lat;
        issue(a, b, c);
        chk({tag, "_busy"}, W'(busy), W'(1));
        wait_done(lat);
        chk({tag, "_lat"}, W'(lat), W'(32));
        chk({tag, "_out"}, out, exp);
        chk({tag, "_zero"}, W'(zero), W'(fx(z)));
        chk({tag, "_neg"}, W'(negative), W'(fx(n)));
        chk({tag, "_ovf"}, W'(overflow), W'(fx(v)));
    endtask

    initial begin
        int lat, cnt;
        // Reset
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_out", out, W'(0));
        reset = 1'b1;

        // Arithmetic
        run_op("add_ovf", 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 0, 1, 1);
        @(posedge clk); @(negedge clk);
        chk("done_pulse", W'(done), W'(0));
        run_op("sub_zero", 32'h00000005, 32'h00000005, 3'b011, 32'h00000000, 1, 0, 0);
        run_op("sub_ovf", 32'h80000000, 32'h00000001, 3'b011, 32'h7FFFFFFF, 0, 0, 1);

        // Logical
        run_op("and", 32'hF0F0AAAA, 32'h0FF05555, 3'b100, 32'h00F00000, 0, 0, 0);
        run_op("or",  32'hF0F0AAAA, 32'h0FF05555, 3'b101, 32'hFFF0FFFF, 0, 1, 0);
        run_op("nor", 32'hF0F0AAAA, 32'h0FF05555, 3'b110, 32'h000F0000, 0, 0, 0);
        run_op("xor", 32'hF0F0AAAA, 32'h0FF05555, 3'b111, 32'hFF00FFFF, 0, 1, 0);
        run_op("rsvd", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 32'h00000000, 1, 0, 0);

        // A start pulse at RUN cycle 10 is ignored
        issue(32'h00000003, 32'h00000004, 3'b010);
        repeat (9) begin @(posedge clk); @(negedge clk); end
        A = 32'h12345678; B = 32'h11111111; control = 3'b111; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        lat = 10;
        while (!done && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
        chk("ign_lat", W'(lat), W'(32));
        chk("ign_out", out, 32'h00000007);

        // Back-to-back: start held in the DONE cycle
        A = 32'h00000010; B = 32'h00000001; control = 3'b011; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", W'(busy), W'(1));
        chk("b2b_done_low", W'(done), W'(0));
        wait_done(lat);
        chk("b2b_lat", W'(lat), W'(32));
        chk("b2b_out", out, 32'h0000000F);

        // Asynchronous reset mid-operation
        issue(32'h7FFFFFFF, 32'h00000001, 3'b010);
        repeat (14) begin @(posedge clk); @(negedge clk); end
        reset = 1'b0;
        #1;
        chk("arst_busy", W'(busy), W'(0));
        chk("arst_done", W'(done), W'(0));
        chk("arst_out", out, W'(0));
        chk("arst_flags", W'({zero, negative, overflow}), W'(0));
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("arst_quiet", W'(cnt), W'(0));

        // Recovery after reset
        run_op("post_rst", 32'h00000001, 32'h00000002, 3'b101, 32'h00000003, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
